// File: rtl/linear_coef_sequencer.sv
// Double-banked coefficient store with a calibration sequencer: software fills a shadow bank,
// and a commit copies it atomically into the active bank between frames, then restarts calibration.
module linear_coef_sequencer #(
  parameter int DSIZE   = 12,
  parameter int NPTS    = 17,
  parameter int TIMEOUT = 64
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [4:0]              cfg_addr,
  input  logic [DSIZE-1:0]        cfg_wdata,
  input  logic                    cfg_commit,
  input  logic                    frame_active,
  output logic                    cal_begin,
  input  logic                    cal_valid,
  output logic [NPTS*DSIZE-1:0]   coef_bus,
  output logic                    lt_enable,
  output logic                    busy,
  output logic                    err,
  output logic                    cfg_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {ST_START, ST_WAIT, ST_RUN, ST_COPY, ST_ERR} state_t;

  state_t           state_r, nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             pending_r;
  logic             addr_ok_s;
  logic [DSIZE-1:0] shadow_r [NPTS];
  logic [DSIZE-1:0] active_r [NPTS];

  function automatic logic [DSIZE-1:0] ramp_value(input int k);
    logic [63:0] v;
    v = 64'(k) << (DSIZE - 4);
    if (v > ((64'd1 << DSIZE) - 64'd1)) begin
      return {DSIZE{1'b1}};
    end else begin
      return v[DSIZE-1:0];
    end
  endfunction

  assign addr_ok_s = (32'(cfg_addr) < NPTS);

  for (genvar k = 0; k < NPTS; k++) begin : g_bus
    assign coef_bus[k*DSIZE +: DSIZE] = active_r[k];
  end

  // Next-state logic; cal_valid only matters while waiting.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      ST_START: nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (cal_valid) begin
          nxt_s = ST_RUN;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          nxt_s = ST_ERR;
        end else begin
          nxt_s = ST_WAIT;
        end
      end
      ST_RUN: begin
        if ((pending_r || cfg_commit) && !frame_active) begin
          nxt_s = ST_COPY;
        end else begin
          nxt_s = ST_RUN;
        end
      end
      ST_COPY: nxt_s = ST_START;
      ST_ERR: begin
        if (cfg_commit) begin
          nxt_s = ST_COPY;
        end else begin
          nxt_s = ST_ERR;
        end
      end
      default: nxt_s = ST_START;
    endcase
  end

  // Timeout counter restarts from zero on every WAIT entry.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_WAIT && nxt_s == ST_WAIT) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Commits seen before or during RUN are remembered until the next copy.
  always_ff @(posedge clock) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (state_r == ST_COPY) begin
      pending_r <= 1'b0;
    end else if (cfg_commit && (state_r == ST_START || state_r == ST_WAIT || state_r == ST_RUN)) begin
      pending_r <= 1'b1;
    end
  end

  // State, banks and registered outputs. Reset parks the FSM in COPY with outputs forced low,
  // so the first edge after release performs a harmless identity copy and lands in START.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r   <= ST_COPY;
      cal_begin <= 1'b0;
      lt_enable <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < NPTS; k++) begin
        shadow_r[k] <= ramp_value(k);
        active_r[k] <= ramp_value(k);
      end
    end else begin
      state_r   <= nxt_s;
      cal_begin <= (nxt_s == ST_START);
      lt_enable <= (nxt_s == ST_RUN);
      busy      <= (nxt_s == ST_COPY) || (nxt_s == ST_START) || (nxt_s == ST_WAIT);
      err       <= (nxt_s == ST_ERR);
      cfg_err   <= cfg_wr && !addr_ok_s;
      if (cfg_wr && addr_ok_s) begin
        shadow_r[cfg_addr] <= cfg_wdata;
      end
      if (state_r == ST_COPY) begin
        for (int k = 0; k < NPTS; k++) begin
          active_r[k] <= shadow_r[k];
        end
      end
    end
  end

endmodule
